// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forward selects, result stages,
// HI/LO bit positions and divider FSM states.
package hazard_scoreboard_pkg;

    localparam int unsigned FWD_RF  = 32'd0;
    localparam int unsigned RES_ALU = 32'd1;
    localparam int unsigned RES_MEM = 32'd2;
    localparam int unsigned HILO_LO = 32'd0;
    localparam int unsigned HILO_HI = 32'd1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic int unsigned fwd_stage(input int unsigned k);
        return k;
    endfunction

endpackage

// File: rtl/hazard_div_fsm.sv
// Multi-cycle divider sequencer: IDLE/BUSY/DONE with a down-counter, cancel
// handling and registered busy/done flags.
module hazard_div_fsm
    import hazard_scoreboard_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic cancel_i,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = $clog2(DIV_LAT);

    div_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    // State, counter and flag registers; flags are loaded with the next state's decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= CW'(DIV_LAT - 1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= DIV_IDLE;
                        cnt_q   <= cnt_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                DIV_BUSY: begin
                    if (cancel_i) begin
                        state_q <= DIV_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= DIV_DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= cnt_q - CW'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                DIV_DONE: begin
                    // Cancel and normal completion both land in IDLE from here.
                    state_q <= DIV_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= DIV_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shadows the E..W pipeline, decides stall and
// per-source forwarding, guards HI/LO and sequences the divider.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int AW         = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int PIPE_DEPTH = 3,
    parameter  int DIV_LAT    = 32,
    localparam int SW         = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [NUM_SRC*AW-1:0] d_src_addr,
    input  logic [NUM_SRC-1:0]    d_src_en,
    input  logic [AW-1:0]         d_dst_addr,
    input  logic                  d_dst_en,
    input  logic [SW-1:0]         d_res_stage,
    input  logic                  d_is_div,
    input  logic [1:0]            d_hilo_r,
    input  logic [1:0]            d_hilo_w,
    input  logic                  pipe_advance,
    input  logic [PIPE_DEPTH-1:0] flush_mask,
    input  logic                  div_cancel,
    output logic                  stall,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic [1:0]            hilo_fwd,
    output logic                  div_busy,
    output logic                  div_done
);

    // Index j of every tracker array holds pipeline stage j+1.
    logic [PIPE_DEPTH-1:0] valid_q, valid_d;
    logic [PIPE_DEPTH-1:0] dst_en_q, dst_en_d;
    logic [AW-1:0]         dst_q    [PIPE_DEPTH];
    logic [AW-1:0]         dst_d    [PIPE_DEPTH];
    logic [SW-1:0]         res_q    [PIPE_DEPTH];
    logic [SW-1:0]         res_d    [PIPE_DEPTH];
    logic [1:0]            hilo_w_q [PIPE_DEPTH];
    logic [1:0]            hilo_w_d [PIPE_DEPTH];

    logic                  up_valid_s  [PIPE_DEPTH];
    logic                  up_dst_en_s [PIPE_DEPTH];
    logic [AW-1:0]         up_dst_s    [PIPE_DEPTH];
    logic [SW-1:0]         up_res_s    [PIPE_DEPTH];
    logic [1:0]            up_hilo_w_s [PIPE_DEPTH];

    logic [NUM_SRC-1:0]    src_stall_s;
    logic                  hilo_stall_s;
    logic                  div_stall_s;
    logic                  issue_s;
    logic                  div_start_s;

    assign issue_s = d_valid & ~stall;

    genvar j;
    for (j = 0; j < PIPE_DEPTH; j++) begin : g_up
        if (j == 0) begin : g_head
            assign up_valid_s[j]  = issue_s;
            assign up_dst_en_s[j] = d_dst_en;
            assign up_dst_s[j]    = d_dst_addr;
            assign up_res_s[j]    = d_res_stage;
            assign up_hilo_w_s[j] = d_hilo_w;
        end else begin : g_body
            assign up_valid_s[j]  = valid_q[j-1];
            assign up_dst_en_s[j] = dst_en_q[j-1];
            assign up_dst_s[j]    = dst_q[j-1];
            assign up_res_s[j]    = res_q[j-1];
            assign up_hilo_w_s[j] = hilo_w_q[j-1];
        end
    end

    // Tracker next state: shift on advance, hold otherwise; flush always clears valid.
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (pipe_advance) begin
                valid_d[k]  = up_valid_s[k] & ~flush_mask[k];
                dst_en_d[k] = up_dst_en_s[k];
                dst_d[k]    = up_dst_s[k];
                res_d[k]    = up_res_s[k];
                hilo_w_d[k] = up_hilo_w_s[k];
            end else begin
                valid_d[k]  = valid_q[k] & ~flush_mask[k];
                dst_en_d[k] = dst_en_q[k];
                dst_d[k]    = dst_q[k];
                res_d[k]    = res_q[k];
                hilo_w_d[k] = hilo_w_q[k];
            end
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            dst_en_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                dst_q[k]    <= '0;
                res_q[k]    <= '0;
                hilo_w_q[k] <= 2'b00;
            end
        end else begin
            valid_q  <= valid_d;
            dst_en_q <= dst_en_d;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                dst_q[k]    <= dst_d[k];
                res_q[k]    <= res_d[k];
                hilo_w_q[k] <= hilo_w_d[k];
            end
        end
    end

    genvar i;
    for (i = 0; i < NUM_SRC; i++) begin : g_src
        logic [AW-1:0]         addr_s;
        logic [PIPE_DEPTH-1:0] hit_s;
        logic [SW-1:0]         sel_s;
        logic                  stl_s;

        assign addr_s = d_src_addr[i*AW +: AW];

        for (j = 0; j < PIPE_DEPTH; j++) begin : g_hit
            assign hit_s[j] = d_src_en[i] & (addr_s != '0) & valid_q[j]
                            & dst_en_q[j] & (dst_q[j] == addr_s);
        end

        // Walk oldest to youngest so the youngest hit overwrites the decision.
        always_comb begin
            sel_s = SW'(FWD_RF);
            stl_s = 1'b0;
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                if (hit_s[k]) begin
                    if (SW'(k + 1) > res_q[k]) begin
                        sel_s = SW'(fwd_stage(k + 1));
                        stl_s = 1'b0;
                    end else begin
                        sel_s = SW'(FWD_RF);
                        stl_s = 1'b1;
                    end
                end else begin
                    sel_s = sel_s;
                    stl_s = stl_s;
                end
            end
        end

        assign fwd_sel[i*SW +: SW] = sel_s;
        assign src_stall_s[i]      = stl_s;
    end

    // HI/LO writers still in flight before the last stage cannot be forwarded.
    always_comb begin
        hilo_stall_s = 1'b0;
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            hilo_stall_s = hilo_stall_s | (valid_q[k] & (|(d_hilo_r & hilo_w_q[k])));
        end
    end

    assign hilo_fwd[HILO_HI] = valid_q[PIPE_DEPTH-1] & d_hilo_r[HILO_HI] & hilo_w_q[PIPE_DEPTH-1][HILO_HI];
    assign hilo_fwd[HILO_LO] = valid_q[PIPE_DEPTH-1] & d_hilo_r[HILO_LO] & hilo_w_q[PIPE_DEPTH-1][HILO_LO];

    assign div_stall_s = (div_busy | div_done) & (d_is_div | (|d_hilo_r) | (|d_hilo_w));
    assign stall       = d_valid & ((|src_stall_s) | hilo_stall_s | div_stall_s);
    assign div_start_s = issue_s & d_is_div & pipe_advance;

    hazard_div_fsm #(
        .DIV_LAT (DIV_LAT)
    ) u_div_fsm (
        .clk      (clk),
        .reset    (reset),
        .start_i  (div_start_s),
        .cancel_i (div_cancel),
        .busy_o   (div_busy),
        .done_o   (div_done)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus a randomized run against
// a stage-list reference model with a divider age counter.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int PD = 3;
    localparam int DL = 32;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_valid;
    logic [NS*AW-1:0]  d_src_addr;
    logic [NS-1:0]     d_src_en;
    logic [AW-1:0]     d_dst_addr;
    logic              d_dst_en;
    logic [SW-1:0]     d_res_stage;
    logic              d_is_div;
    logic [1:0]        d_hilo_r;
    logic [1:0]        d_hilo_w;
    logic              pipe_advance;
    logic [PD-1:0]     flush_mask;
    logic              div_cancel;
    logic              stall;
    logic [NS*SW-1:0]  fwd_sel;
    logic [1:0]        hilo_fwd;
    logic              div_busy;
    logic              div_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stage list 1..PD plus cycles since divide issue (-1 = idle).
    logic          m_valid [1:PD];
    logic [AW-1:0] m_dst   [1:PD];
    logic          m_den   [1:PD];
    int            m_res   [1:PD];
    logic [1:0]    m_hw    [1:PD];
    int            m_age;

    logic             e_stall;
    logic [NS*SW-1:0] e_fwd;
    logic [1:0]       e_hilo;
    logic             e_busy;
    logic             e_done;

    hazard_scoreboard #(.AW(AW), .NUM_SRC(NS), .PIPE_DEPTH(PD), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_src_addr(d_src_addr),
        .d_src_en(d_src_en), .d_dst_addr(d_dst_addr), .d_dst_en(d_dst_en),
        .d_res_stage(d_res_stage), .d_is_div(d_is_div), .d_hilo_r(d_hilo_r),
        .d_hilo_w(d_hilo_w), .pipe_advance(pipe_advance), .flush_mask(flush_mask),
        .div_cancel(div_cancel), .stall(stall), .fwd_sel(fwd_sel), .hilo_fwd(hilo_fwd),
        .div_busy(div_busy), .div_done(div_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 1; k <= PD; k++) begin
            m_valid[k] = 1'b0; m_dst[k] = '0; m_den[k] = 1'b0; m_res[k] = 0; m_hw[k] = 2'b00;
        end
        m_age = -1;
    endtask

    task automatic model_eval();
        logic src_stall, hl_stall, active, found;
        logic [AW-1:0] a;
        src_stall = 1'b0; hl_stall = 1'b0; e_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            a = d_src_addr[i*AW +: AW];
            found = 1'b0;
            for (int k = 1; k <= PD; k++) begin
                if (!found && d_src_en[i] && a != 0 && m_valid[k] && m_den[k] && m_dst[k] == a) begin
                    found = 1'b1;
                    if (k > m_res[k]) e_fwd[i*SW +: SW] = SW'(k);
                    else src_stall = 1'b1;
                end
            end
        end
        for (int k = 1; k < PD; k++)
            if (m_valid[k] && (d_hilo_r & m_hw[k]) != 2'b00) hl_stall = 1'b1;
        e_hilo = m_valid[PD] ? (d_hilo_r & m_hw[PD]) : 2'b00;
        active = (m_age >= 0);
        e_busy = (m_age >= 0) && (m_age < DL);
        e_done = (m_age == DL);
        e_stall = d_valid && (src_stall || hl_stall ||
                  (active && (d_is_div || d_hilo_r != 2'b00 || d_hilo_w != 2'b00)));
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (m_age >= 0) begin
            if (div_cancel) m_age = -1;
            else begin
                m_age++;
                if (m_age > DL) m_age = -1;
            end
        end else if (d_valid && d_is_div && !e_stall && pipe_advance) begin
            m_age = 0;
        end
        if (pipe_advance) begin
            for (int k = PD; k > 1; k--) begin
                m_valid[k] = m_valid[k-1]; m_dst[k] = m_dst[k-1]; m_den[k] = m_den[k-1];
                m_res[k] = m_res[k-1]; m_hw[k] = m_hw[k-1];
            end
            m_valid[1] = d_valid && !e_stall; m_dst[1] = d_dst_addr; m_den[1] = d_dst_en;
            m_res[1] = int'(d_res_stage); m_hw[1] = d_hilo_w;
        end
        for (int k = 1; k <= PD; k++) if (flush_mask[k-1]) m_valid[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_d(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] en, input logic [AW-1:0] dst, input logic de,
                         input int res, input logic dv, input logic [1:0] hr, input logic [1:0] hw);
        d_valid = v; d_src_addr = {s1, s0}; d_src_en = en; d_dst_addr = dst; d_dst_en = de;
        d_res_stage = SW'(res); d_is_div = dv; d_hilo_r = hr; d_hilo_w = hw;
        pipe_advance = 1'b1; flush_mask = '0; div_cancel = 1'b0;
    endtask

    task automatic drain();
        set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        for (int c = 0; c < PD; c++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_d(1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, RES_MEM, 1'b1, 2'b11, 2'b11);
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        n_vec++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b exp 0", stall); n_err++; end
        n_vec++; if (fwd_sel !== 4'b0000) begin $display("FAIL reset_fwd: got %b exp 0000", fwd_sel); n_err++; end
        n_vec++; if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            $display("FAIL reset_div: got busy=%b done=%b exp 0/0", div_busy, div_done); n_err++; end
        n_vec++; if (hilo_fwd !== 2'b00) begin $display("FAIL reset_hilo: got %b exp 00", hilo_fwd); n_err++; end
        @(negedge clk);
        reset = 1'b1;
        drain();
    endtask

    task automatic test_alu_fwd();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        settle();
        n_vec++; if (stall !== 1'b0) begin $display("FAIL alu_issue_stall: got %b exp 0", stall); n_err++; end
        tick();
        set_d(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        settle();
        n_vec++; if (stall !== 1'b1 || fwd_sel !== 4'b0000) begin
            $display("FAIL alu_dep_stall: got stall=%b fwd=%b exp 1/0000", stall, fwd_sel); n_err++; end
        tick();
        settle();
        n_vec++; if (stall !== 1'b0 || fwd_sel !== 4'b0010) begin
            $display("FAIL alu_dep_fwd: got stall=%b fwd=%b exp 0/0010", stall, fwd_sel); n_err++; end
        tick();
        drain();
    endtask

    task automatic test_load_fwd();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, RES_MEM, 1'b0, 2'b00, 2'b00);
        tick();
        set_d(1'b1, 5'd1, 5'd8, 2'b10, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        for (int c = 0; c < 2; c++) begin
            settle();
            n_vec++; if (stall !== 1'b1) begin $display("FAIL load_stall%0d: got %b exp 1", c, stall); n_err++; end
            tick();
        end
        settle();
        n_vec++; if (stall !== 1'b0 || fwd_sel !== 4'b1100) begin
            $display("FAIL load_fwd: got stall=%b fwd=%b exp 0/1100", stall, fwd_sel); n_err++; end
        tick();
        drain();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'b01, 5'd4, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        settle();
        n_vec++; if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            $display("FAIL r0_nomatch: got stall=%b fwd=%b exp 0/0000", stall, fwd_sel); n_err++; end
        tick();
        drain();
    endtask

    task automatic test_youngest();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        tick();
        tick();
        set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        tick();
        set_d(1'b1, 5'd3, 5'd0, 2'b01, 5'd10, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        settle();
        n_vec++; if (stall !== 1'b0 || fwd_sel !== 4'b0010) begin
            $display("FAIL youngest_wins: got stall=%b fwd=%b exp 0/0010", stall, fwd_sel); n_err++; end
        tick();
        drain();
    endtask

    task automatic test_flush();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, RES_ALU, 1'b0, 2'b00, 2'b00);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        pipe_advance = 1'b0; flush_mask = 3'b001;
        tick();
        set_d(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        settle();
        n_vec++; if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            $display("FAIL flush_clears: got stall=%b fwd=%b exp 0/0000", stall, fwd_sel); n_err++; end
        tick();
        drain();
    endtask

    task automatic test_div();
        int pulses;
        pulses = 0;
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b1, 2'b00, 2'b11);
        settle();
        n_vec++; if (stall !== 1'b0 || div_busy !== 1'b0) begin
            $display("FAIL div_issue: got stall=%b busy=%b exp 0/0", stall, div_busy); n_err++; end
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, RES_ALU, 1'b0, 2'b01, 2'b00);
        for (int c = 0; c < DL; c++) begin
            settle();
            if (div_done === 1'b1) pulses++;
            n_vec++; if (div_busy !== 1'b1 || stall !== 1'b1) begin
                $display("FAIL div_busy_c%0d: got busy=%b stall=%b exp 1/1", c, div_busy, stall); n_err++; end
            if (c == 2) begin
                n_vec++; if (hilo_fwd !== 2'b01) begin $display("FAIL div_hilo_fwd: got %b exp 01", hilo_fwd); n_err++; end
            end
            tick();
        end
        settle();
        if (div_done === 1'b1) pulses++;
        n_vec++; if (div_busy !== 1'b0 || div_done !== 1'b1 || stall !== 1'b1) begin
            $display("FAIL div_done_cycle: got busy=%b done=%b stall=%b exp 0/1/1", div_busy, div_done, stall); n_err++; end
        tick();
        settle();
        if (div_done === 1'b1) pulses++;
        n_vec++; if (stall !== 1'b0 || div_done !== 1'b0) begin
            $display("FAIL div_release: got stall=%b done=%b exp 0/0", stall, div_done); n_err++; end
        n_vec++; if (pulses != 1) begin $display("FAIL div_pulse_count: got %0d exp 1", pulses); n_err++; end
        tick();
        drain();
    endtask

    task automatic test_div_cancel();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b1, 2'b00, 2'b11);
        tick();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, RES_ALU, 1'b0, 2'b01, 2'b00);
        for (int c = 1; c < 10; c++) tick();
        div_cancel = 1'b1;
        settle();
        n_vec++; if (div_busy !== 1'b1 || stall !== 1'b1) begin
            $display("FAIL cancel_pre: got busy=%b stall=%b exp 1/1", div_busy, stall); n_err++; end
        tick();
        div_cancel = 1'b0;
        settle();
        n_vec++; if (div_busy !== 1'b0 || div_done !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL cancel_post: got busy=%b done=%b stall=%b exp 0/0/0", div_busy, div_done, stall); n_err++; end
        tick();
        set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++; if (div_done !== 1'b0) begin $display("FAIL cancel_no_done%0d: got %b exp 0", c, div_done); n_err++; end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b1, 2'b00, 2'b11);
        tick();
        set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b0, 2'b00, 2'b00);
        for (int c = 0; c < 4; c++) tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_vec++; if (div_busy !== 1'b0) begin $display("FAIL async_reset_busy: got %b exp 0", div_busy); n_err++; end
        set_d(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, RES_ALU, 1'b1, 2'b01, 2'b00);
        #1;
        n_vec++; if (stall !== 1'b0) begin $display("FAIL async_reset_stall: got %b exp 0", stall); n_err++; end
        @(negedge clk);
        reset = 1'b1;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            d_valid      = ($urandom_range(0, 3) != 0);
            d_src_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            d_src_en     = 2'($urandom_range(0, 3));
            d_dst_addr   = 5'($urandom_range(0, 7));
            d_dst_en     = 1'($urandom_range(0, 1));
            d_res_stage  = SW'($urandom_range(1, 2));
            d_is_div     = ($urandom_range(0, 15) == 0);
            d_hilo_r     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            d_hilo_w     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pipe_advance = ($urandom_range(0, 3) != 0);
            flush_mask   = ($urandom_range(0, 7) == 0) ? PD'($urandom_range(1, 7)) : '0;
            div_cancel   = ($urandom_range(0, 31) == 0);
            settle();
            n_vec++; if (stall !== e_stall) begin $display("FAIL rnd_stall@%0d: got %b exp %b", c, stall, e_stall); n_err++; end
            n_vec++; if (fwd_sel !== e_fwd) begin $display("FAIL rnd_fwd@%0d: got %b exp %b", c, fwd_sel, e_fwd); n_err++; end
            n_vec++; if (hilo_fwd !== e_hilo) begin $display("FAIL rnd_hilo@%0d: got %b exp %b", c, hilo_fwd, e_hilo); n_err++; end
            n_vec++; if (div_busy !== e_busy) begin $display("FAIL rnd_busy@%0d: got %b exp %b", c, div_busy, e_busy); n_err++; end
            n_vec++; if (div_done !== e_done) begin $display("FAIL rnd_done@%0d: got %b exp %b", c, div_done, e_done); n_err++; end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_fwd();
        test_youngest();
        test_flush();
        test_div();
        test_div_cancel();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
